// File: rtl/hazard_ctrl_v_pkg.sv
// hazard_ctrl_v_pkg: shared definitions for the ID-stage hazard controller and the EX stage.
// Contents: default register-address width, forwarding-select encodings, select priority helper.
// No ports; imported with hazard_ctrl_v_pkg::*.
package hazard_ctrl_v_pkg;

   localparam int REG_AW_DEF = 5;

   // Operand source selects seen by the EX-stage operand muxes.
   // 2'b11 is reserved and never produced.
   localparam logic [1:0] FWD_RF    = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b01;
   localparam logic [1:0] FWD_MEMWB = 2'b10;

   // The youngest producer (the one in EX) wins over the one in MEM.
   function automatic logic [1:0] fwd_pick(input logic ex_hit, input logic mem_hit);
      logic [1:0] sel;
      sel = FWD_RF;
      if (ex_hit) begin
         sel = FWD_EXMEM;
      end else if (mem_hit) begin
         sel = FWD_MEMWB;
      end
      return sel;
   endfunction

endpackage

// File: rtl/hazard_ctrl_v_match.sv
// hz_match_v: RAW comparator between one ID source register and one tracker entry.
// Ports: entry {valid, regwrite, rd}, source {use, addr} in; hit out (combinational).
// Register 0 never matches, because writes to x0 are discarded.
module hz_match_v
   import hazard_ctrl_v_pkg::*;
#(
   parameter int REG_AW = REG_AW_DEF
) (
   input  logic              ent_valid_i,
   input  logic              ent_regwrite_i,
   input  logic [REG_AW-1:0] ent_rd_i,
   input  logic              src_use_i,
   input  logic [REG_AW-1:0] src_i,
   output logic              hit_o
);

   assign hit_o = ent_valid_i & ent_regwrite_i & src_use_i
                & (ent_rd_i != '0) & (src_i == ent_rd_i);

endmodule

// File: rtl/hazard_ctrl_v.sv
// hazard_ctrl_v: ID-stage hazard controller. It tracks the producers in EX and MEM and drives
//   stall/idex_bubble (combinational) and forwA/forwB (registered, aligned with the ID/EX operands).
// Ports: clk, rst_n (sync, active-low); ID instruction fields and flush in;
//   stall, idex_bubble, forwA, forwB, isForw_ON, stall_cnt out.
// Build option HAZARD_FORWARD_EN: if defined, forwarding is used and only load-use stalls.
//   If undefined, the design is a full interlock that stalls on any EX/MEM match, and the selects stay at 00.
module hazard_ctrl_v
   import hazard_ctrl_v_pkg::*;
#(
   parameter int REG_AW = REG_AW_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_regwrite,
   input  logic              id_memread,
   input  logic              flush,
   output logic              stall,
   output logic              idex_bubble,
   output logic [1:0]        forwA,
   output logic [1:0]        forwB,
   output logic              isForw_ON,
   output logic [31:0]       stall_cnt
);

   // Tracker: the instruction in EX and the one in MEM. The MEM entry does not need memread,
   // because a load in MEM is always satisfied by the MEM/WB bypass.
   logic              ex_vld_q,  ex_vld_d;
   logic [REG_AW-1:0] ex_rd_q,   ex_rd_d;
   logic              ex_rw_q,   ex_rw_d;
   logic              ex_mr_q,   ex_mr_d;
   logic              mem_vld_q, mem_vld_d;
   logic [REG_AW-1:0] mem_rd_q,  mem_rd_d;
   logic              mem_rw_q,  mem_rw_d;

   logic [1:0]        forw_a_q, forw_a_d;
   logic [1:0]        forw_b_q, forw_b_d;
   logic [31:0]       stall_cnt_q, stall_cnt_d;

   logic              use_a, use_b;
   logic              hit_ex_a, hit_ex_b, hit_mem_a, hit_mem_b;
   logic              any_ex_hit, load_use, hazard;

   // An empty ID slot reads nothing, so it can neither stall nor forward.
   assign use_a = id_valid & id_use_rs1;
   assign use_b = id_valid & id_use_rs2;

   hz_match_v #(.REG_AW(REG_AW)) u_match_ex_a (
      .ent_valid_i(ex_vld_q), .ent_regwrite_i(ex_rw_q), .ent_rd_i(ex_rd_q),
      .src_use_i(use_a), .src_i(id_rs1), .hit_o(hit_ex_a)
   );
   hz_match_v #(.REG_AW(REG_AW)) u_match_ex_b (
      .ent_valid_i(ex_vld_q), .ent_regwrite_i(ex_rw_q), .ent_rd_i(ex_rd_q),
      .src_use_i(use_b), .src_i(id_rs2), .hit_o(hit_ex_b)
   );
   hz_match_v #(.REG_AW(REG_AW)) u_match_mem_a (
      .ent_valid_i(mem_vld_q), .ent_regwrite_i(mem_rw_q), .ent_rd_i(mem_rd_q),
      .src_use_i(use_a), .src_i(id_rs1), .hit_o(hit_mem_a)
   );
   hz_match_v #(.REG_AW(REG_AW)) u_match_mem_b (
      .ent_valid_i(mem_vld_q), .ent_regwrite_i(mem_rw_q), .ent_rd_i(mem_rd_q),
      .src_use_i(use_b), .src_i(id_rs2), .hit_o(hit_mem_b)
   );

   assign any_ex_hit = hit_ex_a | hit_ex_b;
   // A load in EX has no result yet. The consumer waits one cycle and then picks it up from MEM/WB.
   assign load_use   = any_ex_hit & ex_mr_q;

`ifdef HAZARD_FORWARD_EN
   assign hazard    = load_use;
   assign isForw_ON = 1'b1;
`else
   // load_use is a subset of any_ex_hit. It is kept in the OR so the load flag still has a reader.
   assign hazard    = any_ex_hit | hit_mem_a | hit_mem_b | load_use;
   assign isForw_ON = 1'b0;
`endif

   // A redirect kills the ID instruction, so its hazard is irrelevant.
   assign stall       = hazard & ~flush;
   assign idex_bubble = stall | flush;

   always_comb begin
      // Producers always advance. A bubble is inserted when ID does not issue.
      mem_vld_d = ex_vld_q;
      mem_rd_d  = ex_rd_q;
      mem_rw_d  = ex_rw_q;
      ex_vld_d  = id_valid & ~idex_bubble;
      ex_rd_d   = id_rd;
      ex_rw_d   = id_regwrite;
      ex_mr_d   = id_memread;

      forw_a_d  = FWD_RF;
      forw_b_d  = FWD_RF;
`ifdef HAZARD_FORWARD_EN
      if (!idex_bubble) begin
         forw_a_d = fwd_pick(hit_ex_a, hit_mem_a);
         forw_b_d = fwd_pick(hit_ex_b, hit_mem_b);
      end
`endif

      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_vld_q    <= 1'b0;
         ex_rd_q     <= '0;
         ex_rw_q     <= 1'b0;
         ex_mr_q     <= 1'b0;
         mem_vld_q   <= 1'b0;
         mem_rd_q    <= '0;
         mem_rw_q    <= 1'b0;
         forw_a_q    <= FWD_RF;
         forw_b_q    <= FWD_RF;
         stall_cnt_q <= 32'd0;
      end else begin
         ex_vld_q    <= ex_vld_d;
         ex_rd_q     <= ex_rd_d;
         ex_rw_q     <= ex_rw_d;
         ex_mr_q     <= ex_mr_d;
         mem_vld_q   <= mem_vld_d;
         mem_rd_q    <= mem_rd_d;
         mem_rw_q    <= mem_rw_d;
         forw_a_q    <= forw_a_d;
         forw_b_q    <= forw_b_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign forwA     = forw_a_q;
   assign forwB     = forw_b_q;
   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_v.sv
// tb_hazard_ctrl_v: self-checking bench for hazard_ctrl_v, for either build of HAZARD_FORWARD_EN.
// Reference model: history of the last two instructions issued into EX, plus the hazard rules.
module tb_hazard_ctrl_v;

   logic       clk;
   logic       rst_n;
   logic       id_valid;
   logic [4:0] id_rs1, id_rs2, id_rd;
   logic       id_use_rs1, id_use_rs2, id_regwrite, id_memread, flush;
   logic       stall, idex_bubble, isForw_ON;
   logic [1:0] forwA, forwB;
   logic [31:0] stall_cnt;

   hazard_ctrl_v #(.REG_AW(5)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
      .stall(stall), .idex_bubble(idex_bubble), .forwA(forwA), .forwB(forwB),
      .isForw_ON(isForw_ON), .stall_cnt(stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef HAZARD_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   typedef struct { bit v; int rd; bit rw; bit mr; } ins_t;

   ins_t        issued[$];           // [0] = MEM, [1] = EX
   ins_t        bub;
   bit          m_stall, m_bubble;
   logic [1:0]  m_fa, m_fb, exp_fa, exp_fb;
   logic [31:0] exp_cnt;
   int          n_vec, n_err;

   function automatic bit hit(input ins_t p, input logic u, input logic [4:0] src);
      return (id_valid === 1'b1) && (u === 1'b1) && (src != 5'd0) && p.v && p.rw
             && (p.rd == int'(src));
   endfunction

   // Computes the rules from the current ID inputs and the issue history.
   task automatic model_eval();
      ins_t pe, pm;
      bit ea, eb, ma, mb;
      pe = issued[1];
      pm = issued[0];
      ea = hit(pe, id_use_rs1, id_rs1);
      eb = hit(pe, id_use_rs2, id_rs2);
      ma = hit(pm, id_use_rs1, id_rs1);
      mb = hit(pm, id_use_rs2, id_rs2);
      if (FWD) begin
         m_stall = !flush && (ea || eb) && pe.mr;
         m_fa = ea ? 2'b01 : (ma ? 2'b10 : 2'b00);
         m_fb = eb ? 2'b01 : (mb ? 2'b10 : 2'b00);
      end else begin
         m_stall = !flush && (ea || eb || ma || mb);
         m_fa = 2'b00;
         m_fb = 2'b00;
      end
      m_bubble = m_stall || flush;
      if (m_bubble) begin
         m_fa = 2'b00;
         m_fb = 2'b00;
      end
   endtask

   // Advances one clock and updates the model. Returns #1 after the edge.
   task automatic tick();
      ins_t cur;
      @(posedge clk);
      if (!rst_n) begin
         issued = '{bub, bub};
         exp_fa = 2'b00;
         exp_fb = 2'b00;
         exp_cnt = 32'd0;
      end else begin
         if (m_stall && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
         cur = '{v: 1'b1, rd: int'(id_rd), rw: id_regwrite, mr: id_memread};
         issued.push_back((id_valid && !m_stall && !flush) ? cur : bub);
         void'(issued.pop_front());
         exp_fa = m_fa;
         exp_fb = m_fb;
      end
      #1;
   endtask

   task automatic set_id(input bit v, input int r1, input bit u1, input int r2, input bit u2,
                         input int rd, input bit rw, input bit mr, input bit fl);
      id_valid = v; id_rs1 = r1[4:0]; id_use_rs1 = u1; id_rs2 = r2[4:0]; id_use_rs2 = u2;
      id_rd = rd[4:0]; id_regwrite = rw; id_memread = mr; flush = fl;
   endtask

   // Holds the ID instruction until it issues. Checks every cycle. nst = stall cycles.
   task automatic issue(input bit v, input int r1, input bit u1, input int r2, input bit u2,
                        input int rd, input bit rw, input bit mr, input bit fl, output int nst);
      bit done;
      set_id(v, r1, u1, r2, u2, rd, rw, mr, fl);
      nst = 0;
      done = 0;
      for (int k = 0; k < 4 && !done; k++) begin
         #1;
         model_eval();
         n_vec++;
         if (stall !== m_stall) begin
            n_err++; $display("FAIL stall: got %b want %b", stall, m_stall);
         end
         n_vec++;
         if (idex_bubble !== m_bubble) begin
            n_err++; $display("FAIL idex_bubble: got %b want %b", idex_bubble, m_bubble);
         end
         tick();
         n_vec++;
         if (forwA !== exp_fa || forwB !== exp_fb) begin
            n_err++; $display("FAIL forw: got %b/%b want %b/%b", forwA, forwB, exp_fa, exp_fb);
         end
         n_vec++;
         if (stall_cnt !== exp_cnt) begin
            n_err++; $display("FAIL stall_cnt: got %0d want %0d", stall_cnt, exp_cnt);
         end
         if (m_stall) nst++; else done = 1;
      end
      if (!done) begin
         n_vec++; n_err++; $display("FAIL issue_timeout: got %0d stall cycles want at most 3", nst);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      n_vec++;
      if (forwA !== 2'b00 || forwB !== 2'b00) begin
         n_err++; $display("FAIL reset_forw: got %b/%b want 00/00", forwA, forwB);
      end
      n_vec++;
      if (stall_cnt !== 32'd0) begin
         n_err++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt);
      end
      n_vec++;
      if (stall !== 1'b0 || idex_bubble !== 1'b0) begin
         n_err++; $display("FAIL reset_stall: got %b/%b want 0/0", stall, idex_bubble);
      end
      n_vec++;
      if (isForw_ON !== FWD) begin
         n_err++; $display("FAIL isForw_ON: got %b want %b", isForw_ON, FWD);
      end
   endtask

   task automatic test_fwd_ex();
      int nst;
      issue(1, 0, 0, 0, 0, 5, 1, 0, 0, nst);                 // add x5
      issue(1, 5, 1, 7, 1, 6, 1, 0, 0, nst);                 // sub x6,x5,x7
      n_vec++;
      if (nst != (FWD ? 0 : 2)) begin
         n_err++; $display("FAIL fwd_ex_stalls: got %0d want %0d", nst, FWD ? 0 : 2);
      end
      n_vec++;
      if (forwA !== (FWD ? 2'b01 : 2'b00) || forwB !== 2'b00) begin
         n_err++; $display("FAIL fwd_ex_sel: got %b/%b want %b/00", forwA, forwB, FWD ? 2'b01 : 2'b00);
      end
   endtask

   task automatic test_fwd_mem();
      int nst;
      issue(1, 0, 0, 0, 0, 5, 1, 0, 0, nst);                 // add x5
      issue(0, 0, 0, 0, 0, 0, 0, 0, 0, nst);                 // nop
      issue(1, 1, 1, 5, 1, 4, 1, 0, 0, nst);                 // use x5 on rs2
      n_vec++;
      if (nst != (FWD ? 0 : 1) || forwB !== (FWD ? 2'b10 : 2'b00)) begin
         n_err++; $display("FAIL fwd_mem: got stalls %0d forwB %b want %0d %b",
                           nst, forwB, FWD ? 0 : 1, FWD ? 2'b10 : 2'b00);
      end
   endtask

   task automatic test_load_use();
      int nst;
      logic [31:0] c0;
      do_reset();
      c0 = stall_cnt;
      issue(1, 0, 0, 0, 0, 8, 1, 1, 0, nst);                 // lw x8
      issue(1, 8, 1, 8, 1, 9, 1, 0, 0, nst);                 // add x9,x8,x8
      n_vec++;
      if (nst != (FWD ? 1 : 2)) begin
         n_err++; $display("FAIL load_use_stalls: got %0d want %0d", nst, FWD ? 1 : 2);
      end
      n_vec++;
      if (forwA !== (FWD ? 2'b10 : 2'b00) || forwB !== (FWD ? 2'b10 : 2'b00)) begin
         n_err++; $display("FAIL load_use_sel: got %b/%b", forwA, forwB);
      end
      n_vec++;
      if (stall_cnt !== c0 + (FWD ? 32'd1 : 32'd2)) begin
         n_err++; $display("FAIL load_use_cnt: got %0d want %0d", stall_cnt, c0 + (FWD ? 32'd1 : 32'd2));
      end
   endtask

   task automatic test_x0_priority();
      int nst;
      issue(1, 0, 0, 0, 0, 0, 1, 1, 0, nst);                 // load into x0
      issue(1, 0, 1, 0, 1, 2, 1, 0, 0, nst);                 // use x0
      n_vec++;
      if (nst != 0 || forwA !== 2'b00 || forwB !== 2'b00) begin
         n_err++; $display("FAIL x0: got stalls %0d forw %b/%b want 0 00/00", nst, forwA, forwB);
      end
      issue(1, 0, 0, 0, 0, 3, 1, 0, 0, nst);                 // x3 producer (ends in MEM)
      issue(1, 0, 0, 0, 0, 3, 1, 0, 0, nst);                 // x3 producer (ends in EX)
      issue(1, 3, 1, 0, 0, 1, 1, 0, 0, nst);
      n_vec++;
      if (nst != (FWD ? 0 : 2) || forwA !== (FWD ? 2'b01 : 2'b00)) begin
         n_err++; $display("FAIL priority: got stalls %0d forwA %b", nst, forwA);
      end
   endtask

   task automatic test_flush_reset();
      int nst;
      issue(1, 0, 0, 0, 0, 8, 1, 1, 0, nst);                 // lw x8
      set_id(1, 8, 1, 8, 1, 9, 1, 0, 1);                     // dependent add, flushed
      #1;
      model_eval();
      n_vec++;
      if (stall !== 1'b0 || idex_bubble !== 1'b1) begin
         n_err++; $display("FAIL flush_ctl: got %b/%b want 0/1", stall, idex_bubble);
      end
      tick();
      n_vec++;
      if (forwA !== 2'b00 || forwB !== 2'b00) begin
         n_err++; $display("FAIL flush_forw: got %b/%b want 00/00", forwA, forwB);
      end
      issue(1, 0, 0, 0, 0, 8, 1, 1, 0, nst);                 // lw x8 again
      set_id(1, 8, 1, 8, 1, 9, 1, 0, 0);
      #1;
      model_eval();
      n_vec++;
      if (stall !== 1'b1) begin
         n_err++; $display("FAIL pre_reset_stall: got %b want 1", stall);
      end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      #1;
      model_eval();
      n_vec++;
      if (stall !== 1'b0 || m_stall !== 1'b0) begin
         n_err++; $display("FAIL post_reset_stall: got %b want 0", stall);
      end
      n_vec++;
      if (forwA !== 2'b00 || forwB !== 2'b00 || stall_cnt !== 32'd0) begin
         n_err++; $display("FAIL post_reset_regs: got %b/%b cnt %0d want 00/00 0", forwA, forwB, stall_cnt);
      end
      tick();
   endtask

   task automatic test_random();
      int nst;
      for (int i = 0; i < 400; i++) begin
         issue($urandom_range(0, 9) < 8, $urandom_range(0, 3), $urandom_range(0, 1),
               $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
               $urandom_range(0, 1), $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0, nst);
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      bub = '{v: 1'b0, rd: 0, rw: 1'b0, mr: 1'b0};
      issued = '{bub, bub};
      m_stall = 0; m_bubble = 0; m_fa = 0; m_fb = 0;
      exp_fa = 0; exp_fb = 0; exp_cnt = 0;
      rst_n = 1'b0;
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
      test_reset();
      test_fwd_ex();
      test_fwd_mem();
      test_load_use();
      test_x0_priority();
      test_flush_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
